vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster generator, successor to the fixed 800x600 scanner. Runs horizontal and vertical fetch counters with programmable timing, sync polarity and pixel-replication factor. Issues scene-memory read addresses a configurable READ_LAT cycles ahead of the displayed pixel, and delays sync, blank and scene flags so they line up with returned colour data. Sits between the frame buffer read port and the VGA pins, and supplies the once-per-frame vblank pulse used by game logic.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56 / H_SYNC, 120 / H_BP, 64: horizontal porches and sync width (total 1040)
- V_ACTIVE, 600, visible lines
- V_FP, 37 / V_SYNC, 6 / V_BP, 23: vertical porches and sync width (total 666)
- HSYNC_POL, 1 / VSYNC_POL, 1: sync asserted level
- SCALE_SHIFT, 1: logical pixel = 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- SCENE_W, 400 / SCENE_H, 300: logical scene size
- READ_LAT, 1: frame-buffer read latency in cycles, range 1..4
- COLOR_W, 6: colour width (RRGGBB at default)
- X_W, 9 / Y_W, 9: read-address widths
- pixel_clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- rgb_color  in  COLOR_W  colour returned by the frame buffer READ_LAT cycles after rd_en
- rd_x  out  X_W  logical column to read
- rd_y  out  Y_W  logical row to read
- rd_en  out  1  read strobe; high when the fetch position lies inside the scene
- rgb_out  out  COLOR_W  pixel colour to the DAC pins
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- blank  out  1  high outside the active area
- vblank_start  out  1  one-cycle pulse at the first blanking line
- frame_cnt  out  16  frames completed, wraps

## Operation
- Fetch counters fh (0..H_TOTAL-1) and fv (0..V_TOTAL-1) advance every cycle. fh wraps to 0. fv increments on fh wrap and wraps to 0 after V_TOTAL-1.
- Fetch-side flags:
  - f_active = fh<H_ACTIVE & fv<V_ACTIVE
  - rd_x = fh>>SCALE_SHIFT and rd_y = fv>>SCALE_SHIFT, truncated to X_W/Y_W
  - f_scene = f_active & rd_x<SCENE_W & rd_y<SCENE_H
  - rd_en = f_scene
- Display-side signals are the fetch-side flags delayed by READ_LAT registers. This delays f_active, f_scene, the hsync window, the vsync window and the vblank-edge flag.
- Window definitions on the fetch position:
  - hsync window: H_ACTIVE+H_FP <= fh < H_ACTIVE+H_FP+H_SYNC
  - vsync window: V_ACTIVE+V_FP <= fv < V_ACTIVE+V_FP+V_SYNC
  - vblank edge: fh==0 & fv==V_ACTIVE
- Output drive:
  - hsync = HSYNC_POL when the delayed window is set, else ~HSYNC_POL; vsync follows the same rule with VSYNC_POL
  - blank = ~active_d
  - rgb_out = active_d ? (scene_d ? rgb_color : fill) : 0, where fill = 0 unless VGA_BORDER_EN
- frame_cnt increments in the cycle vblank_start is high.

## Timing
- Reset values:
  - fh = fv = 0 and all delay registers cleared
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - blank = 1, rgb_out = 0, rd_en = 0 (forced low while rst is high)
  - vblank_start = 0, frame_cnt = 0
- First cycle after rst is released: fetch (0,0), rd_en = 1, rd_x = rd_y = 0. blank falls READ_LAT cycles later.
- rgb_out is a combinational mux of rgb_color and registered flags; no extra latency is added on the colour path.
- Line period is H_TOTAL cycles. Frame period is H_TOTAL*V_TOTAL cycles (692640 at defaults).
- Pulse widths:
  - hsync: H_SYNC cycles per line
  - vsync: V_SYNC lines
  - vblank_start: exactly 1 cycle per frame
- Wrap-around: fetch look-ahead across a line or frame end is handled by the counters themselves, so no special address case exists.
- Reset mid-frame: all state returns to reset values on the next edge. A partial vsync pulse may be truncated, and no vblank_start is emitted for the aborted frame.
- frame_cnt 0xFFFF wraps to 0x0000 on the next vblank_start.

## Configuration
- VGA_BORDER_EN:
  - defined: adds input border_color [COLOR_W], sampled every cycle; active pixels outside the scene show border_color
  - undefined: the port is absent and those pixels show 0

## Structure
- Package vga_pkg holds:
  - the default SVGA timing constants and COLOR_W
  - H_TOTAL/V_TOTAL derivation functions
  - a clog2-based counter-width helper
- Sub-module vga_delay_line(W, DEPTH): a shift register used for the READ_LAT alignment of the {active, scene, hwin, vwin, vedge} bundle.

## Test plan
- Defaults, rgb_color tied to 0x2A, rst for 3 cycles then run:
  - hsync high for exactly 120 cycles starting 857 cycles after release (856 + READ_LAT)
  - line period 1040 cycles
- Defaults, full frame:
  - vsync high for 6 lines starting at line 637
  - vblank_start pulses once per 692640 cycles
  - frame_cnt reads 3 after three frames
- READ_LAT=3, frame-buffer model returning {rd_y[2:0], rd_x[2:0]} after 3 cycles:
  - every non-blank rgb_out equals the expected pattern for screen (x,y)
  - first visible pixel appears 3 cycles after release
- SCALE_SHIFT=1:
  - rd_x sequence 0,0,1,1,...,399,399 per line
  - rd_y constant across screen lines 2k and 2k+1
- SCENE_W=320 with VGA_BORDER_EN and border_color=0x15:
  - rd_en low for screen x 640..799
  - rgb_out=0x15 there, 0 in blanking
- Assert rst at fv=300, fh=500:
  - next cycle all outputs are at reset values
  - frame_cnt=0
  - the first vblank_start arrives 600*1040 + READ_LAT cycles after release

Source files
------------

// File: rtl/vga_pkg.sv
// Default SVGA timing constants and sizing helpers shared by the VGA raster generator.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 56;
   localparam int DEF_H_SYNC   = 120;
   localparam int DEF_H_BP     = 64;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 37;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 23;
   localparam int DEF_COLOR_W  = 6;

   // Fetch-side flags carried through the read-latency alignment pipe.
   typedef struct packed {
      logic active;
      logic scene;
      logic hwin;
      logic vwin;
      logic vedge;
   } vga_flags_t;

   function automatic int h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Width able to hold every value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to align fetch flags with read data.
module vga_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         pixel_clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with look-ahead frame-buffer addressing.
// Define VGA_BORDER_EN to add a border_color input for active pixels outside the scene.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic HSYNC_POL   = 1'b1,
   parameter logic VSYNC_POL   = 1'b1,
   parameter int   SCALE_SHIFT = 1,
   parameter int   SCENE_W     = 400,
   parameter int   SCENE_H     = 300,
   parameter int   READ_LAT    = 1,
   parameter int   COLOR_W     = DEF_COLOR_W,
   parameter int   X_W         = 9,
   parameter int   Y_W         = 9
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic [COLOR_W-1:0] rgb_color,
`ifdef VGA_BORDER_EN
   input  logic [COLOR_W-1:0] border_color,
`endif
   output logic [X_W-1:0]     rd_x,
   output logic [Y_W-1:0]     rd_y,
   output logic               rd_en,
   output logic [COLOR_W-1:0] rgb_out,
   output logic               hsync,
   output logic               vsync,
   output logic               blank,
   output logic               vblank_start,
   output logic [15:0]        frame_cnt
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HC_W    = cnt_width(H_TOTAL);
   localparam int VC_W    = cnt_width(V_TOTAL);

   localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [X_W:0]    SCN_W  = (X_W+1)'(SCENE_W);
   localparam logic [Y_W:0]    SCN_H  = (Y_W+1)'(SCENE_H);

   logic [HC_W-1:0]    fh_q, fh_d;
   logic [VC_W-1:0]    fv_q, fv_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [HC_W-1:0]    fh_scaled;
   logic [VC_W-1:0]    fv_scaled;
   logic               f_active, f_scene, f_hwin, f_vwin, f_vedge;
   vga_flags_t         f_flags, d_flags;
   logic [COLOR_W-1:0] fill;

   always_comb begin
      fh_d = fh_q + HC_W'(1);
      fv_d = fv_q;
      if (fh_q == H_LAST) begin
         fh_d = '0;
         fv_d = (fv_q == V_LAST) ? '0 : fv_q + VC_W'(1);
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         fh_q        <= '0;
         fv_q        <= '0;
         frame_cnt_q <= '0;
      end else begin
         fh_q        <= fh_d;
         fv_q        <= fv_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Fetch side: addresses lead the display by READ_LAT cycles.
   assign fh_scaled = fh_q >> SCALE_SHIFT;
   assign fv_scaled = fv_q >> SCALE_SHIFT;
   assign rd_x      = X_W'(fh_scaled);
   assign rd_y      = Y_W'(fv_scaled);

   assign f_active = (fh_q < H_ACT) && (fv_q < V_ACT);
   assign f_scene  = f_active && ({1'b0, rd_x} < SCN_W) && ({1'b0, rd_y} < SCN_H);
   assign f_hwin   = (fh_q >= HS_BEG) && (fh_q < HS_END);
   assign f_vwin   = (fv_q >= VS_BEG) && (fv_q < VS_END);
   assign f_vedge  = (fh_q == '0) && (fv_q == V_ACT);
   assign f_flags  = {f_active, f_scene, f_hwin, f_vwin, f_vedge};

   assign rd_en = f_scene & ~rst;

   vga_delay_line #(
      .W     ($bits(vga_flags_t)),
      .DEPTH (READ_LAT)
   ) u_align (
      .pixel_clk (pixel_clk),
      .rst       (rst),
      .d_i       (f_flags),
      .q_o       (d_flags)
   );

   // Display side: flags now line up with the colour returned for them.
`ifdef VGA_BORDER_EN
   assign fill = border_color;
`else
   assign fill = '0;
`endif

   always_comb begin
      rgb_out = '0;
      if (d_flags.active) rgb_out = d_flags.scene ? rgb_color : fill;
   end

   assign hsync        = d_flags.hwin ? HSYNC_POL : ~HSYNC_POL;
   assign vsync        = d_flags.vwin ? VSYNC_POL : ~VSYNC_POL;
   assign blank        = ~d_flags.active;
   assign vblank_start = d_flags.vedge;
   assign frame_cnt_d  = frame_cnt_q + {15'd0, d_flags.vedge};
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: one default-timing instance and one shrunken-timing instance
// (READ_LAT=3, active-low syncs, 2x scaling) fed by a frame-buffer model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

`ifdef VGA_BORDER_EN
   localparam logic [5:0] FILL = 6'h15;
`else
   localparam logic [5:0] FILL = 6'h00;
`endif

   // Default-timing instance, colour tied to 0x2A.
   logic [5:0]  d_rgbin = 6'h2A;
   logic [8:0]  d_rdx, d_rdy;
   logic        d_rden, d_hs, d_vs, d_bl, d_vb;
   logic [5:0]  d_rgbo;
   logic [15:0] d_fc;

   vga_timing_gen dut_def (
      .pixel_clk    (clk),
      .rst          (rst),
      .rgb_color    (d_rgbin),
`ifdef VGA_BORDER_EN
      .border_color (6'h15),
`endif
      .rd_x         (d_rdx),
      .rd_y         (d_rdy),
      .rd_en        (d_rden),
      .rgb_out      (d_rgbo),
      .hsync        (d_hs),
      .vsync        (d_vs),
      .blank        (d_bl),
      .vblank_start (d_vb),
      .frame_cnt    (d_fc)
   );

   // Small instance: H_TOTAL=24, V_TOTAL=18, frame = 432 cycles.
   logic [5:0]  s_rgbin = 6'h3F;
   logic [3:0]  s_rdx, s_rdy;
   logic        s_rden, s_hs, s_vs, s_bl, s_vb;
   logic [5:0]  s_rgbo;
   logic [15:0] s_fc;

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_SHIFT(1),
      .SCENE_W(6), .SCENE_H(5), .READ_LAT(3), .COLOR_W(6), .X_W(4), .Y_W(4)
   ) dut_s (
      .pixel_clk    (clk),
      .rst          (rst),
      .rgb_color    (s_rgbin),
`ifdef VGA_BORDER_EN
      .border_color (6'h15),
`endif
      .rd_x         (s_rdx),
      .rd_y         (s_rdy),
      .rd_en        (s_rden),
      .rgb_out      (s_rgbo),
      .hsync        (s_hs),
      .vsync        (s_vs),
      .blank        (s_bl),
      .vblank_start (s_vb),
      .frame_cnt    (s_fc)
   );

   // Leaves the caller at the negedge where rst has just dropped (cycle 0).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         nvec++;
         if ({d_hs, d_vs, d_bl, d_vb, d_rden, d_rgbo, d_fc} !== {4'b0010, 1'b0, 6'h00, 16'h0000}) begin
            nerr++;
            $display("FAIL reset_def got hs=%b vs=%b bl=%b vb=%b en=%b rgb=%h fc=%h want hs=0 vs=0 bl=1 vb=0 en=0 rgb=00 fc=0000",
                     d_hs, d_vs, d_bl, d_vb, d_rden, d_rgbo, d_fc);
         end
         nvec++;
         if ({s_hs, s_vs, s_bl, s_vb, s_rden, s_rgbo, s_fc, s_rdx, s_rdy} !== {4'b1110, 1'b0, 6'h00, 16'h0000, 4'h0, 4'h0}) begin
            nerr++;
            $display("FAIL reset_small got hs=%b vs=%b bl=%b vb=%b en=%b rgb=%h fc=%h x=%0d y=%0d want hs=1 vs=1 bl=1 vb=0 en=0 rgb=00 fc=0000 x=0 y=0",
                     s_hs, s_vs, s_bl, s_vb, s_rden, s_rgbo, s_fc, s_rdx, s_rdy);
         end
      end
   endtask

   task automatic test_default_line();
      int   first_rise, second_rise, hs_width;
      logic hs_prev;
      first_rise  = -1;
      second_rise = -1;
      hs_width    = 0;
      hs_prev     = 1'b0;
      do_reset();
      for (int k = 0; k < 3*1040 + 4; k++) begin
         int         fh, fv, j;
         logic       e_en, e_act, e_hw;
         logic [8:0] e_x, e_y;
         logic [5:0] e_rgb;
         if (k > 0) @(negedge clk);
         #1;
         fh    = k % 1040;
         fv    = k / 1040;
         j     = k - 1;
         e_en  = (fh < 800);
         e_x   = 9'(fh >> 1);
         e_y   = 9'(fv >> 1);
         e_act = (j >= 0) && ((j % 1040) < 800);
         e_hw  = (j >= 0) && ((j % 1040) >= 856) && ((j % 1040) < 976);
         e_rgb = e_act ? 6'h2A : 6'h00;
         nvec++;
         if ({d_rden, d_rdx, d_rdy} !== {e_en, e_x, e_y}) begin
            nerr++;
            $display("FAIL def_fetch k=%0d got en=%b x=%0d y=%0d want en=%b x=%0d y=%0d",
                     k, d_rden, d_rdx, d_rdy, e_en, e_x, e_y);
         end
         nvec++;
         if ({d_hs, d_vs, d_bl, d_vb} !== {e_hw, 1'b0, ~e_act, 1'b0}) begin
            nerr++;
            $display("FAIL def_sync k=%0d got hs=%b vs=%b bl=%b vb=%b want hs=%b vs=0 bl=%b vb=0",
                     k, d_hs, d_vs, d_bl, d_vb, e_hw, ~e_act);
         end
         nvec++;
         if ({d_rgbo, d_fc} !== {e_rgb, 16'h0000}) begin
            nerr++;
            $display("FAIL def_rgb k=%0d got rgb=%h fc=%h want rgb=%h fc=0000", k, d_rgbo, d_fc, e_rgb);
         end
         if (d_hs && !hs_prev) begin
            if (first_rise < 0) first_rise = k;
            else if (second_rise < 0) second_rise = k;
         end
         if (d_hs && second_rise < 0) hs_width++;
         hs_prev = d_hs;
      end
      nvec++;
      if (first_rise != 857) begin
         nerr++;
         $display("FAIL def_hs_start got %0d want 857", first_rise);
      end
      nvec++;
      if (second_rise - first_rise != 1040) begin
         nerr++;
         $display("FAIL def_line_period got %0d want 1040", second_rise - first_rise);
      end
      nvec++;
      if (hs_width != 120) begin
         nerr++;
         $display("FAIL def_hs_width got %0d want 120", hs_width);
      end
   endtask

   task automatic test_small_frames();
      logic [5:0] hist [4];
      int         nvb;
      nvb = 0;
      do_reset();
      for (int k = 0; k < 2*432 + 40; k++) begin
         int         fh, fv, j, dh, dv;
         logic       e_en, e_act, e_scn, e_hw, e_vw, e_ve;
         logic [3:0] e_x, e_y;
         logic [5:0] e_rgb;
         logic [1:0] rp, wp;
         if (k > 0) @(negedge clk);
         rp      = 2'(k - 3);
         wp      = 2'(k);
         s_rgbin = (k >= 3) ? hist[rp] : 6'h3F;
         #1;
         fh    = k % 24;
         fv    = (k / 24) % 18;
         e_x   = 4'(fh >> 1);
         e_y   = 4'(fv >> 1);
         e_en  = (fh < 16) && (fv < 12) && ((fh >> 1) < 6) && ((fv >> 1) < 5);
         j     = k - 3;
         dh    = (j >= 0) ? (j % 24) : 0;
         dv    = (j >= 0) ? ((j / 24) % 18) : 0;
         e_act = (j >= 0) && (dh < 16) && (dv < 12);
         e_scn = e_act && ((dh >> 1) < 6) && ((dv >> 1) < 5);
         e_hw  = (j >= 0) && (dh >= 18) && (dh < 21);
         e_vw  = (j >= 0) && (dv >= 14) && (dv < 16);
         e_ve  = (j >= 0) && (dh == 0) && (dv == 12);
         e_rgb = !e_act ? 6'h00 : (e_scn ? {3'(dv >> 1), 3'(dh >> 1)} : FILL);
         nvec++;
         if ({s_rden, s_rdx, s_rdy} !== {e_en, e_x, e_y}) begin
            nerr++;
            $display("FAIL small_fetch k=%0d got en=%b x=%0d y=%0d want en=%b x=%0d y=%0d",
                     k, s_rden, s_rdx, s_rdy, e_en, e_x, e_y);
         end
         nvec++;
         if ({s_hs, s_vs, s_bl, s_vb} !== {~e_hw, ~e_vw, ~e_act, e_ve}) begin
            nerr++;
            $display("FAIL small_sync k=%0d got hs=%b vs=%b bl=%b vb=%b want hs=%b vs=%b bl=%b vb=%b",
                     k, s_hs, s_vs, s_bl, s_vb, ~e_hw, ~e_vw, ~e_act, e_ve);
         end
         nvec++;
         if (s_rgbo !== e_rgb) begin
            nerr++;
            $display("FAIL small_rgb k=%0d got %h want %h", k, s_rgbo, e_rgb);
         end
         nvec++;
         if (s_fc !== 16'(nvb)) begin
            nerr++;
            $display("FAIL small_fc k=%0d got %0d want %0d", k, s_fc, nvb);
         end
         if (e_ve) nvb++;
         hist[wp] = {s_rdy[2:0], s_rdx[2:0]};
      end
      nvec++;
      if (s_fc !== 16'd2) begin
         nerr++;
         $display("FAIL small_fc_two_frames got %0d want 2", s_fc);
      end
   endtask

   task automatic test_midframe_reset();
      int   wait_cnt;
      logic seen;
      do_reset();
      // Stop inside the small instance's vsync pulse (display line 15).
      repeat (15*24 + 5) @(negedge clk);
      #1;
      nvec++;
      if ({s_vs, s_fc} !== {1'b0, 16'd1}) begin
         nerr++;
         $display("FAIL mid_pre_state got vs=%b fc=%0d want vs=0 fc=1", s_vs, s_fc);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if ({d_rden, s_rden} !== 2'b00) begin
         nerr++;
         $display("FAIL mid_rden_forced got def=%b small=%b want 0 0", d_rden, s_rden);
      end
      @(negedge clk);
      #1;
      nvec++;
      if ({s_hs, s_vs, s_bl, s_vb, s_rden, s_rgbo, s_fc} !== {4'b1110, 1'b0, 6'h00, 16'h0000}) begin
         nerr++;
         $display("FAIL mid_reset_small got hs=%b vs=%b bl=%b vb=%b en=%b rgb=%h fc=%h want hs=1 vs=1 bl=1 vb=0 en=0 rgb=00 fc=0000",
                  s_hs, s_vs, s_bl, s_vb, s_rden, s_rgbo, s_fc);
      end
      nvec++;
      if ({d_hs, d_vs, d_bl, d_vb, d_rden, d_rgbo, d_fc} !== {4'b0010, 1'b0, 6'h00, 16'h0000}) begin
         nerr++;
         $display("FAIL mid_reset_def got hs=%b vs=%b bl=%b vb=%b en=%b rgb=%h fc=%h want hs=0 vs=0 bl=1 vb=0 en=0 rgb=00 fc=0000",
                  d_hs, d_vs, d_bl, d_vb, d_rden, d_rgbo, d_fc);
      end
      rst      = 1'b0;
      wait_cnt = 0;
      seen     = 1'b0;
      while (!seen && wait_cnt < 1000) begin
         if (s_vb === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            #1;
            wait_cnt++;
         end
      end
      nvec++;
      if (!seen) begin
         nerr++;
         $display("FAIL mid_first_vblank got timeout after %0d cycles want 291", wait_cnt);
      end else if (wait_cnt != 12*24 + 3) begin
         nerr++;
         $display("FAIL mid_first_vblank got %0d cycles want 291", wait_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_default_line();
      test_small_frames();
      test_midframe_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
